// File: rtl/next_pc_unit_pkg.sv
// Shared types and defaults for the program-counter stage.
// Holds the FSM and next-PC source encodings plus the reset/exception constants.
package next_pc_unit_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        SRC_SEQ = 3'd0,
        SRC_BR  = 3'd1,
        SRC_J   = 3'd2,
        SRC_JR  = 3'd3,
        SRC_EXC = 3'd4
    } src_t;

    localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_8000;
    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;

endpackage

// File: rtl/next_pc_unit_target.sv
// Combinational redirect target computation and priority selection.
// Priority is exc > jr > j > br; src is SRC_SEQ when nothing redirects.
module next_pc_target
    import next_pc_unit_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic              br_take,
    input  logic [15:0]       br_imm,
    input  logic [ADDR_W-1:0] br_pc4,
    input  logic              j_take,
    input  logic [25:0]       j_target,
    input  logic              jr_take,
    input  logic [ADDR_W-1:0] jr_addr,
    input  logic              exc,
    output logic [ADDR_W-1:0] target,
    output src_t              src
);

    logic [ADDR_W-1:0] br_off;
    logic [ADDR_W-1:0] br_tgt;
    logic [ADDR_W-1:0] j_tgt;
    logic [ADDR_W-1:0] jr_tgt;
    logic [ADDR_W-1:0] exc_tgt;

    // Word offset sign-extended and scaled to bytes; the add wraps naturally.
    assign br_off  = {{(ADDR_W-18){br_imm[15]}}, br_imm, 2'b00};
    assign br_tgt  = br_pc4 + br_off;
    assign jr_tgt  = jr_addr & ~ADDR_W'(3);
    assign exc_tgt = ADDR_W'(EXC_VECTOR);

    if (ADDR_W > 28) begin : g_region
        assign j_tgt = {br_pc4[ADDR_W-1:28], j_target, 2'b00};
    end else begin : g_flat
        assign j_tgt = {j_target, 2'b00};
    end

    always_comb begin
        target = '0;
        src    = SRC_SEQ;
        if (exc) begin
            target = exc_tgt;
            src    = SRC_EXC;
        end else if (jr_take) begin
            target = jr_tgt;
            src    = SRC_JR;
        end else if (j_take) begin
            target = j_tgt;
            src    = SRC_J;
        end else if (br_take) begin
            target = br_tgt;
            src    = SRC_BR;
        end
    end

endmodule

// File: rtl/next_pc_unit.sv
// PC register with a one-entry redirect buffer used while the pipeline stalls.
// A buffered exception can only be displaced by a newer exception.
module next_pc_unit
    import next_pc_unit_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter logic [63:0] RESET_PC   = 64'(DEF_RESET_PC),
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              stall,
    input  logic              br_take,
    input  logic [15:0]       br_imm,
    input  logic [ADDR_W-1:0] br_pc4,
    input  logic              j_take,
    input  logic [25:0]       j_target,
    input  logic              jr_take,
    input  logic [ADDR_W-1:0] jr_addr,
    input  logic              exc,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              flush,
    output logic              pending
);

    localparam logic [ADDR_W-1:0] RST_PC = RESET_PC[ADDR_W-1:0];

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pend_addr, pend_addr_nxt;
    logic              pend_exc, pend_exc_nxt;
    logic [ADDR_W-1:0] pc_nxt;
    logic              flush_nxt;

    logic [ADDR_W-1:0] target;
    src_t              src;
    logic              redirect;
    logic              live_wins;

    next_pc_target #(
        .ADDR_W     (ADDR_W),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_target (
        .br_take  (br_take),
        .br_imm   (br_imm),
        .br_pc4   (br_pc4),
        .j_take   (j_take),
        .j_target (j_target),
        .jr_take  (jr_take),
        .jr_addr  (jr_addr),
        .exc      (exc),
        .target   (target),
        .src      (src)
    );

    assign redirect  = (src != SRC_SEQ);
    assign live_wins = redirect && (exc || !pend_exc);
    assign pc_plus4  = pc + ADDR_W'(4);
    assign pending   = (state == HOLD);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= RUN;
            pc        <= RST_PC;
            flush     <= 1'b0;
            pend_addr <= '0;
            pend_exc  <= 1'b0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            flush     <= flush_nxt;
            pend_addr <= pend_addr_nxt;
            pend_exc  <= pend_exc_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        flush_nxt     = 1'b0;
        pend_addr_nxt = pend_addr;
        pend_exc_nxt  = pend_exc;
        unique case (state)
            RUN: begin
                if (!stall) begin
                    pc_nxt    = redirect ? target : pc_plus4;
                    flush_nxt = redirect;
                end else if (redirect) begin
                    pend_addr_nxt = target;
                    pend_exc_nxt  = exc;
                    state_nxt     = HOLD;
                end
            end
            HOLD: begin
                if (stall) begin
                    if (live_wins) begin
                        pend_addr_nxt = target;
                        pend_exc_nxt  = exc;
                    end
                end else begin
                    pc_nxt       = live_wins ? target : pend_addr;
                    flush_nxt    = 1'b1;
                    pend_exc_nxt = 1'b0;
                    state_nxt    = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed plus randomized bench for next_pc_unit against a behavioural model.
module tb_next_pc_unit;

    localparam logic [31:0] EXC_V = 32'h0000_8000;
    localparam logic [31:0] RST_V = 32'h0000_0000;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        stall = 1'b0;
    logic        br_take = 1'b0;
    logic [15:0] br_imm = '0;
    logic [31:0] br_pc4 = '0;
    logic        j_take = 1'b0;
    logic [25:0] j_target = '0;
    logic        jr_take = 1'b0;
    logic [31:0] jr_addr = '0;
    logic        exc = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        flush;
    logic        pending;

    int total = 0;
    int bad = 0;

    // behavioural model state
    logic [31:0] m_pc = '0;
    bit          m_flush = 0;
    bit          m_pend = 0;
    bit          m_bexc = 0;
    logic [31:0] m_baddr = '0;

    next_pc_unit dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .stall    (stall),
        .br_take  (br_take),
        .br_imm   (br_imm),
        .br_pc4   (br_pc4),
        .j_take   (j_take),
        .j_target (j_target),
        .jr_take  (jr_take),
        .jr_addr  (jr_addr),
        .exc      (exc),
        .pc       (pc),
        .pc_plus4 (pc_plus4),
        .flush    (flush),
        .pending  (pending)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] want_target();
        if (exc) return EXC_V;
        if (jr_take) return (jr_addr / 4) * 4;
        if (j_take) return (br_pc4 & 32'hF000_0000) + 32'(j_target) * 4;
        return br_pc4 + 32'(int'($signed(br_imm)) * 4);
    endfunction

    task automatic model_edge();
        bit          r;
        bit          live;
        logic [31:0] t;
        r = exc | jr_take | j_take | br_take;
        t = want_target();
        if (Reset) begin
            m_pc = RST_V; m_flush = 0; m_pend = 0; m_bexc = 0; m_baddr = '0;
        end else if (!m_pend) begin
            m_flush = 0;
            if (!stall) begin
                m_flush = r;
                m_pc = r ? t : m_pc + 32'd4;
            end else if (r) begin
                m_pend = 1; m_baddr = t; m_bexc = exc;
            end
        end else begin
            live = r && (exc || !m_bexc);
            if (stall) begin
                m_flush = 0;
                if (live) begin m_baddr = t; m_bexc = exc; end
            end else begin
                m_pc = live ? t : m_baddr;
                m_flush = 1; m_pend = 0; m_bexc = 0;
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge Clk);
        #1;
        check("pc", 64'(pc), 64'(m_pc));
        check("pc_plus4", 64'(pc_plus4), 64'(m_pc + 32'd4));
        check("flush", 64'(flush), 64'(m_flush));
        check("pending", 64'(pending), 64'(m_pend));
    endtask

    task automatic idle();
        stall = 0; br_take = 0; j_take = 0; jr_take = 0; exc = 0;
    endtask

    initial begin
        #1;
        Reset = 1; idle();
        step();
        check("rst_pc", 64'(pc), 64'(RST_V));
        check("rst_flush", 64'(flush), 64'd0);
        check("rst_pending", 64'(pending), 64'd0);
        Reset = 0;
        for (int i = 1; i <= 3; i++) begin
            step();
            check("seq_pc", 64'(pc), 64'(4 * i));
            check("seq_flush", 64'(flush), 64'd0);
        end

        br_take = 1; br_pc4 = 32'h104; br_imm = 16'hFFFE;
        step();
        check("br_pc", 64'(pc), 64'h0FC);
        check("br_flush", 64'(flush), 64'd1);
        idle();
        step();
        check("br_flush_end", 64'(flush), 64'd0);

        j_take = 1; j_target = 26'h40; br_pc4 = 32'h1000_0008;
        step();
        check("j_pc", 64'(pc), 64'h1000_0100);
        idle();

        stall = 1; jr_take = 1; jr_addr = 32'h2003;
        step();
        check("jr_pending", 64'(pending), 64'd1);
        check("jr_hold", 64'(pc), 64'h1000_0100);
        jr_take = 0;
        step(); step();
        check("jr_hold2", 64'(pc), 64'h1000_0100);
        stall = 0;
        step();
        check("jr_pc", 64'(pc), 64'h2000);
        check("jr_flush", 64'(flush), 64'd1);
        check("jr_pend_clr", 64'(pending), 64'd0);

        stall = 1; exc = 1;
        step();
        exc = 0; br_take = 1; br_pc4 = 32'h500; br_imm = 16'h0010;
        step();
        idle();
        step();
        check("exc_keep", 64'(pc), 64'(EXC_V));
        check("exc_flush", 64'(flush), 64'd1);

        stall = 1; br_take = 1; br_pc4 = 32'h300; br_imm = 16'h0001;
        step();
        check("hold_pend", 64'(pending), 64'd1);
        br_take = 0; Reset = 1;
        step();
        check("rh_pc", 64'(pc), 64'(RST_V));
        check("rh_pending", 64'(pending), 64'd0);
        Reset = 0;
        step();
        stall = 0;
        step();
        check("rh_noflush", 64'(flush), 64'd0);
        check("rh_seq", 64'(pc), 64'(RST_V + 32'd4));

        for (int i = 0; i < 3000; i++) begin
            Reset    = ($urandom % 250) == 0;
            stall    = ($urandom % 3) == 0;
            br_take  = ($urandom % 5) == 0;
            j_take   = ($urandom % 7) == 0;
            jr_take  = ($urandom % 7) == 0;
            exc      = ($urandom % 12) == 0;
            br_imm   = 16'($urandom);
            br_pc4   = $urandom;
            j_target = 26'($urandom);
            jr_addr  = $urandom;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
